// File: rtl/writeback_stage.sv
// Write-back stage: picks ALU result or load data and drives a one-cycle register-file write.
// Write appears 1 cycle after accept (DATA) or 1 cycle after memory_valid (LW); in_ready drops while a load is outstanding.
module writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     instruction,
  input  logic [DATA_WIDTH-1:0]     in,
  input  logic [DATA_WIDTH-1:0]     memory_in,
  input  logic                      memory_valid,
  output logic                      wb_enable,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      mem_timeout,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    retired_count
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t                    state, next_state;
  logic [TW-1:0]             wait_cnt;
  logic [4:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] dest;
  logic                      is_lw, is_data, accept;
  logic                      ld_addr, ld_alu, ld_mem, clr_cnt, inc_cnt, timeout_nxt;
  logic [REG_ADDR_WIDTH-1:0] addr_nxt;
  logic                      unused_instr_bits;

  assign opcode            = instruction[DATA_WIDTH-1 -: 5];
  assign dest              = instruction[DATA_WIDTH-6 -: REG_ADDR_WIDTH];
  assign unused_instr_bits = ^instruction[DATA_WIDTH-6-REG_ADDR_WIDTH:0];
  assign is_lw             = (opcode == 5'd0);
  assign is_data           = (opcode >= 5'd2) && (opcode <= 5'd18);

  assign in_ready = (state != WAIT_MEM);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    next_state  = state;
    ld_addr     = 1'b0;
    ld_alu      = 1'b0;
    ld_mem      = 1'b0;
    clr_cnt     = 1'b0;
    inc_cnt     = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, WRITE: begin
        next_state = IDLE;
        if (accept) begin
          if (is_lw) begin
            ld_addr    = 1'b1;
            clr_cnt    = 1'b1;
            next_state = WAIT_MEM;
          end else if (is_data) begin
            ld_addr    = 1'b1;
            ld_alu     = 1'b1;
            next_state = WRITE;
          end
        end
      end
      WAIT_MEM: begin
        // memory_valid takes priority over an expiring timeout
        if (memory_valid) begin
          ld_mem     = 1'b1;
          next_state = WRITE;
        end else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          next_state  = IDLE;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign addr_nxt = ld_addr ? dest : wb_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt      <= '0;
      wb_enable     <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      mem_timeout   <= 1'b0;
      retired_count <= '0;
    end else begin
      if (clr_cnt) begin
        wait_cnt <= '0;
      end else if (inc_cnt) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      wb_addr <= addr_nxt;
      if (ld_alu) begin
        wb_data <= in;
      end else if (ld_mem) begin
        wb_data <= memory_in;
      end
      // r0 is hard-wired zero: the FSM still visits WRITE but the strobe stays low
      wb_enable     <= (next_state == WRITE) && (addr_nxt != '0);
      mem_timeout   <= timeout_nxt;
      retired_count <= retired_count + {{(COUNT_WIDTH-1){1'b0}}, wb_enable};
    end
  end

endmodule
